fetch_stage: RTL and testbench

- PC generator plus IF/ID pipeline register, directly upstream of the instruction memory.
- Drives the instruction memory word address.
- Captures the combinational read data into an IF/ID register together with the PC.
- Handles decode stalls, branch/jump redirects, and a sticky fault on misaligned redirect targets.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_pc_gen.sv | 41 ++++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 fetch front end.
// Holds the IF/ID record, the fetch FSM states and an alignment helper.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_e;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection.
// Priority: reset, halt, redirect, stall, then sequential advance.
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (halt_i) begin
      pc_d = pc_q;
    end else if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (!stall_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: drives the instruction memory address and captures the
// returned word with its PC into the IF/ID register; halts on a bad redirect.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_i,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            fetch_fault
);

  fetch_state_e    state_q, state_d;
  if_id_t          if_id_q, if_id_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc;
  logic            bad_redirect;
  logic            freeze_pc;

  assign bad_redirect = redirect_valid && !is_word_aligned(redirect_pc);
  // Once halted (or about to halt) the PC must not move at all.
  assign freeze_pc    = (state_q == HALT) || bad_redirect;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .halt_i        (freeze_pc),
    .pc_o          (pc)
  );

  always_comb begin
    state_d = state_q;
    if_id_d = if_id_q;
    fault_d = fault_q;
    unique case (state_q)
      RUN: begin
        if (bad_redirect) begin
          fault_d        = 1'b1;
          state_d        = HALT;
          if_id_d.valid  = 1'b0;
          if_id_d.instr  = NOP_INSTR;
        end else if (redirect_valid) begin
          if_id_d.valid  = 1'b0;
          if_id_d.instr  = NOP_INSTR;
        end else if (!stall_i) begin
          if_id_d.valid  = 1'b1;
          if_id_d.pc     = pc;
          if_id_d.pc4    = pc + 32'd4;
          if_id_d.instr  = imem_rdata;
        end
      end
      HALT: begin
        if_id_d.valid = 1'b0;
        if_id_d.instr = NOP_INSTR;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      if_id_q <= '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR};
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if_id_q <= if_id_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push expected post-edge
// state; a negedge monitor pops and compares against the DUT outputs.
module tb_fetch_stage;

  typedef struct {
    int          step;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        fault;
    logic        chkPc;
  } expT;

  logic        clk;
  logic        rst;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        stall;
  logic        redirValid;
  logic [31:0] redirPc;
  logic        ifIdValid;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdPc4;
  logic [31:0] ifIdInstr;
  logic        fetchFault;

  expT expQ[$];
  int  compareCount  = 0;
  int  mismatchCount = 0;
  int  stepNum       = 0;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imemAddr),
    .imem_rdata     (imemRdata),
    .stall_i        (stall),
    .redirect_valid (redirValid),
    .redirect_pc    (redirPc),
    .if_id_valid    (ifIdValid),
    .if_id_pc       (ifIdPc),
    .if_id_pc4      (ifIdPc4),
    .if_id_instr    (ifIdInstr),
    .fetch_fault    (fetchFault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: three real words, everything else a tagged pattern.
  always_comb begin
    case (imemAddr)
      32'h0000_0000: imemRdata = 32'h0000_2083;
      32'h0000_0004: imemRdata = 32'h0040_2103;
      32'h0000_0008: imemRdata = 32'h0080_A183;
      default:       imemRdata = {16'hDEAD, imemAddr[15:0]};
    endcase
  end

  task automatic checkOutput(input int step, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    compareCount++;
    if (act !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL step%0d %s: got 0x%08h expected 0x%08h", step, field, act, exp);
    end
  endtask

  // Drive inputs for one edge, then record what the DUT should show after it.
  task automatic applyStimulus(input logic r, input logic s, input logic rv,
                               input logic [31:0] rpc, input logic [31:0] eAddr,
                               input logic eValid, input logic [31:0] ePc,
                               input logic [31:0] ePc4, input logic [31:0] eInstr,
                               input logic eFault, input logic eChkPc);
    expT e;
    rst        = r;
    stall      = s;
    redirValid = rv;
    redirPc    = rpc;
    @(posedge clk);
    #2;
    stepNum++;
    e.step  = stepNum;
    e.addr  = eAddr;
    e.valid = eValid;
    e.pc    = ePc;
    e.pc4   = ePc4;
    e.instr = eInstr;
    e.fault = eFault;
    e.chkPc = eChkPc;
    expQ.push_back(e);
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.step, "imem_addr", imemAddr, e.addr);
        checkOutput(e.step, "valid", {31'b0, ifIdValid}, {31'b0, e.valid});
        checkOutput(e.step, "instr", ifIdInstr, e.instr);
        checkOutput(e.step, "fault", {31'b0, fetchFault}, {31'b0, e.fault});
        if (e.chkPc) begin
          checkOutput(e.step, "pc", ifIdPc, e.pc);
          checkOutput(e.step, "pc4", ifIdPc4, e.pc4);
        end
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin : stimulus
    int drain;
    rst = 1'b1; stall = 1'b0; redirValid = 1'b0; redirPc = 32'h0;
    //            rst  stl  rv   rpc            addr          v    pc            pc4           instr          f    chk
    applyStimulus(1'b1,1'b0,1'b0,32'h0,         32'h0000_0000,1'b0,32'h0,        32'h0,        NOP,           1'b0,1'b1);
    // Free run from reset.
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0004,1'b1,32'h0,        32'h4,        32'h0000_2083, 1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0008,1'b1,32'h4,        32'h8,        32'h0040_2103, 1'b0,1'b1);
    // Three stalled cycles hold everything.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0,1'b1,1'b0,32'h0,       32'h0000_0008,1'b1,32'h4,        32'h8,        32'h0040_2103, 1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_000C,1'b1,32'h8,        32'hC,        32'h0080_A183, 1'b0,1'b1);
    // Redirect beats stall; one bubble, then the target.
    applyStimulus(1'b0,1'b1,1'b1,32'h40,        32'h0000_0040,1'b0,32'h0,        32'h0,        NOP,           1'b0,1'b0);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0044,1'b1,32'h40,       32'h44,       32'hDEAD_0040, 1'b0,1'b1);
    // Misaligned redirect faults and halts; later redirects ignored.
    applyStimulus(1'b0,1'b0,1'b1,32'h42,        32'h0000_0044,1'b0,32'h0,        32'h0,        NOP,           1'b1,1'b0);
    applyStimulus(1'b0,1'b0,1'b1,32'h80,        32'h0000_0044,1'b0,32'h0,        32'h0,        NOP,           1'b1,1'b0);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0044,1'b0,32'h0,        32'h0,        NOP,           1'b1,1'b0);
    // Reset out of HALT.
    applyStimulus(1'b1,1'b0,1'b1,32'h80,        32'h0000_0000,1'b0,32'h0,        32'h0,        NOP,           1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0004,1'b1,32'h0,        32'h4,        32'h0000_2083, 1'b0,1'b1);
    // Wrap-around at the top of the address space.
    applyStimulus(1'b0,1'b0,1'b1,32'hFFFF_FFFC, 32'hFFFF_FFFC,1'b0,32'h0,        32'h0,        NOP,           1'b0,1'b0);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0000,1'b1,32'hFFFF_FFFC,32'h0,        32'hDEAD_FFFC, 1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0004,1'b1,32'h0,        32'h4,        32'h0000_2083, 1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0008,1'b1,32'h4,        32'h8,        32'h0040_2103, 1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_000C,1'b1,32'h8,        32'hC,        32'h0080_A183, 1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0010,1'b1,32'hC,        32'h10,       32'hDEAD_000C, 1'b0,1'b1);
    // Reset wins over a simultaneous stall and redirect.
    applyStimulus(1'b1,1'b1,1'b1,32'h80,        32'h0000_0000,1'b0,32'h0,        32'h0,        NOP,           1'b0,1'b1);
    applyStimulus(1'b0,1'b0,1'b0,32'h0,         32'h0000_0004,1'b1,32'h0,        32'h4,        32'h0000_2083, 1'b0,1'b1);

    drain = 0;
    while (expQ.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (expQ.size() > 0) begin
      mismatchCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
